// File: rtl/mmult_result_printer.sv
// mmult_result_printer
//   Consumer end of the matrix-multiplier result interface. On a rising edge
//   of mat_valid (seen while idle) the 3x3 result on c_mat is captured and
//   printed as ASCII hex text, row-major, one byte at a time:
//     "eeeee eeeee eeeee\r\n" x 3   (digit count = ceil(ELEM_W/4))
//   Optional build macro MMULT_PRINT_HEADER_EN prefixes the text with "C:\r\n".
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   mat_valid      result-valid level from the multiplier
//   c_mat          9 elements, element k=(row*3+col) at c_mat[ELEM_W*k +: ELEM_W]
//   byte_data      ASCII byte offered downstream
//   byte_valid     byte_data is valid
//   byte_ready     downstream accepts byte_data this cycle
//   busy           a print is in progress
//   done           one-cycle pulse after the last byte is accepted
//
// Handshake: a byte transfers on a clock edge where byte_valid && byte_ready.
// While byte_valid is high and byte_ready low, byte_data holds its value.
// The following byte is presented on the same edge as a transfer, so the
// stream runs at one byte per cycle when byte_ready stays high.
module mmult_result_printer #(
  parameter int ELEM_W    = 17,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mat_valid,
  input  logic [9*ELEM_W-1:0]   c_mat,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int ND = (ELEM_W + 3) / 4;          // hex digits per element
  localparam int DW = ND * 4;                    // element width padded to nibbles
  localparam int IW = (ND > 1) ? $clog2(ND) : 1; // digit index width
  localparam logic [IW-1:0] LAST_DIGIT = IW'(ND - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DIGIT,
    S_SEP,
    S_CR,
    S_LF
  } state_t;

  state_t              state, state_n;
  logic [IW-1:0]       digit, digit_n;
  logic [1:0]          col, col_n;
  logic [1:0]          row, row_n;
  logic                mat_valid_q;
  logic [9*ELEM_W-1:0] mat_q;

`ifdef MMULT_PRINT_HEADER_EN
  logic [1:0]          hdr, hdr_n;
`endif

  logic                fire;
  logic                trigger;
  logic                finish;
  logic [9*ELEM_W-1:0] src;
  logic [ELEM_W-1:0]   elem;
  logic [DW-1:0]       padded;
  logic [3:0]          nib;
  logic [7:0]          byte_n;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'b0000, n};
    // 'A'-10 = 0x37, 'a'-10 = 0x57
    return (UPPERCASE ? 8'h37 : 8'h57) + {4'b0000, n};
  endfunction

  // Next-state, counters and the byte to present after this edge.
  always_comb begin
    fire    = byte_valid && byte_ready;
    trigger = (state == S_IDLE) && mat_valid && !mat_valid_q;
    finish  = 1'b0;
    state_n = state;
    digit_n = digit;
    col_n   = col;
    row_n   = row;
`ifdef MMULT_PRINT_HEADER_EN
    hdr_n   = hdr;
`endif

    case (state)
      S_IDLE: begin
        if (trigger) begin
`ifdef MMULT_PRINT_HEADER_EN
          state_n = S_HEADER;
          hdr_n   = 2'd0;
`else
          state_n = S_DIGIT;
`endif
          digit_n = '0;
          col_n   = 2'd0;
          row_n   = 2'd0;
        end
      end
`ifdef MMULT_PRINT_HEADER_EN
      S_HEADER: begin
        if (fire) begin
          if (hdr == 2'd3) begin
            hdr_n   = 2'd0;
            state_n = S_DIGIT;
          end else begin
            hdr_n = hdr + 2'd1;
          end
        end
      end
`endif
      S_DIGIT: begin
        if (fire) begin
          if (digit == LAST_DIGIT) begin
            digit_n = '0;
            if (col == 2'd2) begin
              col_n   = 2'd0;
              state_n = S_CR;
            end else begin
              col_n   = col + 2'd1;
              state_n = S_SEP;
            end
          end else begin
            digit_n = digit + IW'(1);
          end
        end
      end
      S_SEP: if (fire) state_n = S_DIGIT;
      S_CR:  if (fire) state_n = S_LF;
      S_LF: begin
        if (fire) begin
          if (row == 2'd2) begin
            row_n   = 2'd0;
            state_n = S_IDLE;
            finish  = 1'b1;
          end else begin
            row_n   = row + 2'd1;
            state_n = S_DIGIT;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // On the trigger edge the copy is not yet loaded, so read c_mat directly.
    src    = trigger ? c_mat : mat_q;
    elem   = src[ELEM_W*(int'(row_n)*3 + int'(col_n)) +: ELEM_W];
    padded = '0;
    padded[ELEM_W-1:0] = elem;
    nib    = padded[4*(ND-1-int'(digit_n)) +: 4];

    case (state_n)
`ifdef MMULT_PRINT_HEADER_EN
      S_HEADER: begin
        case (hdr_n)
          2'd0:    byte_n = 8'h43;
          2'd1:    byte_n = 8'h3A;
          2'd2:    byte_n = 8'h0D;
          default: byte_n = 8'h0A;
        endcase
      end
`endif
      S_DIGIT: byte_n = hex_char(nib);
      S_SEP:   byte_n = 8'h20;
      S_CR:    byte_n = 8'h0D;
      S_LF:    byte_n = 8'h0A;
      default: byte_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      digit       <= '0;
      col         <= 2'd0;
      row         <= 2'd0;
      mat_valid_q <= 1'b0;
      mat_q       <= '0;
      byte_data   <= 8'h00;
      byte_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef MMULT_PRINT_HEADER_EN
      hdr         <= 2'd0;
`endif
    end else begin
      state       <= state_n;
      digit       <= digit_n;
      col         <= col_n;
      row         <= row_n;
      mat_valid_q <= mat_valid;
      if (trigger) mat_q <= c_mat;
      byte_data   <= byte_n;
      byte_valid  <= (state_n != S_IDLE);
      busy        <= (state_n != S_IDLE);
      done        <= finish;
`ifdef MMULT_PRINT_HEADER_EN
      hdr         <= hdr_n;
`endif
    end
  end

endmodule

// File: tb/tb_mmult_result_printer.sv
// tb_mmult_result_printer
//   Two printers (uppercase and lowercase) share all inputs. The expected
//   text is built from the matrix with plain integer arithmetic and lookup
//   strings, then compared against the bytes that actually transferred.
module tb_mmult_result_printer;

  localparam int EW = 17;
  localparam int ND = 5;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            mat_valid = 1'b0;
  logic            byte_ready = 1'b1;
  logic [9*EW-1:0] c_mat = '0;

  logic [7:0] data_uc, data_lc;
  logic       valid_uc, valid_lc, busy_uc, busy_lc, done_uc, done_lc;

  always #5 clk = ~clk;

  mmult_result_printer #(.ELEM_W(EW), .UPPERCASE(1'b1)) u_dut_uc (
    .clk(clk), .reset_n(reset_n), .mat_valid(mat_valid), .c_mat(c_mat),
    .byte_data(data_uc), .byte_valid(valid_uc), .byte_ready(byte_ready),
    .busy(busy_uc), .done(done_uc)
  );

  mmult_result_printer #(.ELEM_W(EW), .UPPERCASE(1'b0)) u_dut_lc (
    .clk(clk), .reset_n(reset_n), .mat_valid(mat_valid), .c_mat(c_mat),
    .byte_data(data_lc), .byte_valid(valid_lc), .byte_ready(byte_ready),
    .busy(busy_lc), .done(done_lc)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_lc_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got_lc_q[$];
  int         mat[9];
  int         ready_mode = 0;
  int         busy_cycles = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  int         done_gap = 0;
  int         hoff = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic build_expected();
    string up = "0123456789ABCDEF";
    string lo = "0123456789abcdef";
    exp_q.delete();
    exp_lc_q.delete();
`ifdef MMULT_PRINT_HEADER_EN
    exp_q.push_back(8'h43);    exp_lc_q.push_back(8'h43);
    exp_q.push_back(8'h3A);    exp_lc_q.push_back(8'h3A);
    exp_q.push_back(8'h0D);    exp_lc_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);    exp_lc_q.push_back(8'h0A);
`endif
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        for (int d = ND - 1; d >= 0; d--) begin
          int nib;
          nib = (mat[r*3+c] >> (4*d)) & 15;
          exp_q.push_back(up[nib]);
          exp_lc_q.push_back(lo[nib]);
        end
        if (c < 2) begin
          exp_q.push_back(8'h20); exp_lc_q.push_back(8'h20);
        end else begin
          exp_q.push_back(8'h0D); exp_lc_q.push_back(8'h0D);
          exp_q.push_back(8'h0A); exp_lc_q.push_back(8'h0A);
        end
      end
    end
  endtask

  task automatic drive_matrix();
    for (int k = 0; k < 9; k++) begin
      logic [31:0] v;
      v = mat[k];
      c_mat[EW*k +: EW] = v[EW-1:0];
    end
  endtask

  task automatic random_matrix();
    for (int k = 0; k < 9; k++) mat[k] = int'($urandom_range(0, 32'h1FFFF));
  endtask

  // ---------------- byte_ready driver ----------------
  initial begin
    int rc = 0;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      case (ready_mode)
        1:       byte_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
        2:       byte_ready = 1'($urandom_range(0, 1));
        default: byte_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor (samples mid-cycle) ----------------
  initial begin
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_prev) check("stall_hold", data_uc, prev_data);
      stall_prev = valid_uc && !byte_ready;
      prev_data  = data_uc;
      if (valid_uc && byte_ready) begin
        if (got_q.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        got_q.push_back(data_uc);
      end
      if (valid_lc && byte_ready) got_lc_q.push_back(data_lc);
      if (busy_uc) busy_cycles++;
      if (done_prev) check("done_width", done_uc, 1'b0);
      if (done_uc) begin
        done_cnt++;
        done_gap = cyc - last_cyc;
      end
      done_prev = done_uc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_print(input int mode);
    ready_mode = mode;
    build_expected();
    drive_matrix();
    mat_valid = 1'b0;
    tick();
    tick();
    got_q.delete();
    got_lc_q.delete();
    busy_cycles = 0;
    mat_valid = 1'b1;
    tick();
    check("first_valid", valid_uc, 1'b1);
  endtask

  task automatic wait_done(input int start_done);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (done_cnt > start_done) break;
      tick();
    end
    check("done_seen", (done_cnt > start_done), 1'b1);
    tick();
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (got_q.size() >= n) break;
      tick();
    end
    check("wait_bytes", (got_q.size() >= n), 1'b1);
  endtask

  task automatic compare_text(input string tag);
    int n;
    check({tag, "_len_uc"}, got_q.size(), exp_q.size());
    check({tag, "_len_lc"}, got_lc_q.size(), exp_lc_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_uc[%0d]", tag, i), got_q[i], exp_q[i]);
    n = (got_lc_q.size() < exp_lc_q.size()) ? got_lc_q.size() : exp_lc_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_lc[%0d]", tag, i), got_lc_q[i], exp_lc_q[i]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    string s_uc, s_lc, s_mid;
`ifdef MMULT_PRINT_HEADER_EN
    hoff = 4;
`endif

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_valid", valid_uc, 1'b0);
    check("rst_busy", busy_uc, 1'b0);
    check("rst_done", done_uc, 1'b0);
    check("rst_data", data_uc, 8'h00);
    reset_n = 1'b1;
    tick();

    // 1: all zero, full throughput
    for (int k = 0; k < 9; k++) mat[k] = 0;
    d0 = done_cnt;
    start_print(0);
    wait_done(d0);
    compare_text("zero");
    check("zero_len_const", got_q.size(), 57 + hoff);
    check("zero_busy_cycles", busy_cycles, 57 + hoff);
    check("zero_contiguous", last_cyc - first_cyc + 1, 57 + hoff);
    check("zero_done_gap", done_gap, 1);
`ifdef MMULT_PRINT_HEADER_EN
    if (got_q.size() >= 4) begin
      check("hdr0", got_q[0], 8'h43);
      check("hdr1", got_q[1], 8'h3A);
      check("hdr2", got_q[2], 8'h0D);
      check("hdr3", got_q[3], 8'h0A);
    end
`endif

    // 2: letter digits and top-digit padding
    for (int k = 0; k < 9; k++) mat[k] = 0;
    mat[0] = 32'h1FFFF;
    mat[4] = 32'h0ABCD;
    d0 = done_cnt;
    start_print(0);
    wait_done(d0);
    compare_text("letters");
    s_uc = "1FFFF";
    s_lc = "1ffff";
    s_mid = "0ABCD";
    if (got_q.size() >= hoff + 30 && got_lc_q.size() >= hoff + 30) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t2_uc_e00[%0d]", i), got_q[hoff+i], s_uc[i]);
        check($sformatf("t2_lc_e00[%0d]", i), got_lc_q[hoff+i], s_lc[i]);
        check($sformatf("t2_uc_e11[%0d]", i), got_q[hoff+25+i], s_mid[i]);
      end
      check("t2_lc_e11_b2", got_lc_q[hoff+27], 8'h62);
    end

    // 3: backpressure 1,0,0,1 and random ready
    random_matrix();
    d0 = done_cnt;
    start_print(1);
    wait_done(d0);
    compare_text("bp");
    for (int n = 0; n < 3; n++) begin
      random_matrix();
      d0 = done_cnt;
      start_print(2);
      wait_done(d0);
      compare_text($sformatf("rnd%0d", n));
    end

    // 4: second rise and c_mat change mid-print, then mat_valid held high
    random_matrix();
    d0 = done_cnt;
    start_print(0);
    wait_bytes(10);
    mat_valid = 1'b0;
    tick();
    mat_valid = 1'b1;
    c_mat = {$urandom, $urandom, $urandom, $urandom, $urandom};
    wait_done(d0);
    compare_text("retrig");
    for (int i = 0; i < 30; i++) tick();
    check("no_retrig_bytes", got_q.size(), exp_q.size());
    check("no_retrig_done", done_cnt, d0 + 1);
    check("no_retrig_busy", busy_uc, 1'b0);

    // 5: reset mid-print with mat_valid high, then restart from byte 0
    random_matrix();
    start_print(0);
    wait_bytes(20);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", valid_uc, 1'b0);
    check("midrst_busy", busy_uc, 1'b0);
    check("midrst_done", done_uc, 1'b0);
    tick();
    tick();
    got_q.delete();
    got_lc_q.delete();
    d0 = done_cnt;
    reset_n = 1'b1;
    begin
      int i;
      for (i = 0; i < 4; i++) begin
        tick();
        if (valid_uc) break;
      end
      check("restart_valid", valid_uc, 1'b1);
    end
    wait_done(d0);
    compare_text("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
